// File: rtl/noc_fifo_pkg.sv
// Shared definitions for both ends of the NoC-to-tile asynchronous packet FIFO.
// Gray helpers work on 32-bit values; callers cast the result to their pointer width.
package noc_fifo_pkg;

    localparam int unsigned NOC_FIFO_AWIDTH = 3;
    localparam int unsigned NOC_FIFO_PTR_W  = NOC_FIFO_AWIDTH + 1;

    typedef logic [NOC_FIFO_PTR_W-1:0] noc_fifo_ptr_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs make the MSB-first prefix XOR width-independent.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/noc_fifo_rx_skid.sv
// Two-entry FIFO-ordered valid/ready buffer feeding tile logic from the read port.
module noc_fifo_rx_skid #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             rd_idx_q, rd_idx_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop, do_push, wr_idx;

    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        // With count 2 the free slot is the one being popped, i.e. rd_idx itself.
        wr_idx  = rd_idx_q ^ count_q[0];

        mem_d    = mem_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_idx] = data_i;
        end
        if (do_pop) begin
            rd_idx_d = ~rd_idx_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_idx_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/util_sync.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into the local clock domain.
module util_sync #(
    parameter int unsigned Width  = 4,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage_q [Stages];
    logic [Width-1:0] stage_d [Stages];

    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < int'(Stages); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(Stages); i++) begin
            if (reset_i) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/noc_fifo_rx_port.sv
// Tile-side read end of the NoC-to-tile async packet FIFO: pointer sync, status,
// fetch from storage and a 2-entry valid/ready output buffer.
module noc_fifo_rx_port
    import noc_fifo_pkg::*;
#(
    parameter int unsigned AWIDTH      = NOC_FIFO_AWIDTH,
    parameter int unsigned PACKET_SIZE = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [PACKET_SIZE-1:0] fifo_data_i,
    input  logic [AWIDTH:0]        fifo_waddr_i,
    output logic [AWIDTH:0]        fifo_raddr_o,
    output logic [PACKET_SIZE-1:0] packet_o,
    output logic                   packet_valid_o,
    input  logic                   packet_ready_i,
    output logic [AWIDTH:0]        fill_level_o,
    output logic                   empty_o,
    output logic                   err_o
);

    localparam int unsigned PtrW = AWIDTH + 1;

    logic [PtrW-1:0] wsync_gray, wsync_bin, level;
    logic [PtrW-1:0] rptr_bin_q, rptr_bin_d;
    logic [PtrW-1:0] raddr_q, raddr_d;
    logic [PtrW-1:0] fill_q, fill_d;
    logic            empty_q, empty_d;
    logic            err_q, err_d;
    logic            empty, overflow, fetch;
    logic [1:0]      buf_count;

    util_sync #(
        .Width  (PtrW),
        .Stages (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (fifo_waddr_i),
        .q_o     (wsync_gray)
    );

    always_comb begin
        wsync_bin = PtrW'(gray2bin(32'(wsync_gray)));
        empty     = (wsync_gray == PtrW'(bin2gray(32'(rptr_bin_q))));
        level     = wsync_bin - rptr_bin_q;
        // level > 2^AWIDTH: top bit set with any lower bit also set.
        overflow  = level[AWIDTH] && (|level[AWIDTH-1:0]);
        // Only registered buffer occupancy gates the fetch; no path from packet_ready_i.
        fetch     = !empty && !err_q && !overflow && (buf_count != 2'd2);

        rptr_bin_d = fetch ? rptr_bin_q + PtrW'(1) : rptr_bin_q;
        raddr_d    = PtrW'(bin2gray(32'(rptr_bin_d)));
        err_d      = err_q | overflow;
        fill_d     = level;
        empty_d    = empty;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_bin_q <= '0;
            raddr_q    <= '0;
            fill_q     <= '0;
            empty_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            rptr_bin_q <= rptr_bin_d;
            raddr_q    <= raddr_d;
            fill_q     <= fill_d;
            empty_q    <= empty_d;
            err_q      <= err_d;
        end
    end

    noc_fifo_rx_skid #(
        .Width (PACKET_SIZE)
    ) u_skid (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fetch),
        .data_i  (fifo_data_i),
        .pop_i   (packet_ready_i),
        .data_o  (packet_o),
        .valid_o (packet_valid_o),
        .count_o (buf_count)
    );

    assign fifo_raddr_o = raddr_q;
    assign fill_level_o = fill_q;
    assign empty_o      = empty_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_noc_fifo_rx_port.sv
// Scoreboard bench for noc_fifo_rx_port with a model of the NoC-side storage.
module tb_noc_fifo_rx_port;
    import noc_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [7:0] fifo_data_i;
    logic [3:0] fifo_waddr_i;
    logic [3:0] fifo_raddr_o;
    logic [7:0] packet_o;
    logic       packet_valid_o;
    logic       packet_ready_i;
    logic [3:0] fill_level_o;
    logic       empty_o;
    logic       err_o;

    logic [7:0] mem [8];
    logic [3:0] rbin;

    logic [7:0] exp_pkt_q [$];
    logic [3:0] exp_raddr_q [$];
    logic [3:0] prev_raddr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    noc_fifo_rx_port #(
        .AWIDTH      (3),
        .PACKET_SIZE (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .fifo_data_i    (fifo_data_i),
        .fifo_waddr_i   (fifo_waddr_i),
        .fifo_raddr_o   (fifo_raddr_o),
        .packet_o       (packet_o),
        .packet_valid_o (packet_valid_o),
        .packet_ready_i (packet_ready_i),
        .fill_level_o   (fill_level_o),
        .empty_o        (empty_o),
        .err_o          (err_o)
    );

    always_comb begin
        rbin        = 4'(gray2bin(32'(fifo_raddr_o)));
        fifo_data_i = mem[rbin[2:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: packets leaving on a handshake and each new read pointer published.
    always @(negedge clk) begin
        if (reset_i) begin
            prev_raddr <= 4'd0;
        end else begin
            if (packet_valid_o && packet_ready_i) begin
                if (exp_pkt_q.size() == 0) begin
                    check("unexpected_packet", {24'd0, packet_o}, 32'hFFFF_FFFF);
                end else begin
                    check("packet_data", {24'd0, packet_o}, {24'd0, exp_pkt_q.pop_front()});
                end
            end
            if (fifo_raddr_o != prev_raddr) begin
                if (exp_raddr_q.size() == 0) begin
                    check("unexpected_raddr", {28'd0, fifo_raddr_o}, 32'hFFFF_FFFF);
                end else begin
                    check("raddr_seq", {28'd0, fifo_raddr_o}, {28'd0, exp_raddr_q.pop_front()});
                end
            end
            prev_raddr <= fifo_raddr_o;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i        = 1'b1;
        fifo_waddr_i   = 4'd0;
        packet_ready_i = 1'b0;
        step(2);
        exp_pkt_q.delete();
        exp_raddr_q.delete();
        reset_i = 1'b0;
    endtask

    // Storage write by the modelled NoC side plus the matching expected packets.
    task automatic load(input logic [7:0] base, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[(first + i) % 8] = base + 8'(i);
            exp_pkt_q.push_back(base + 8'(i));
        end
    endtask

    task automatic push_raddr(input int from, input int n);
        for (int i = 0; i < n; i++) begin
            exp_raddr_q.push_back(4'(bin2gray(32'((from + i + 1) % 16))));
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((exp_pkt_q.size() != 0 || exp_raddr_q.size() != 0) && k < budget) begin
            step(1);
            k++;
        end
        check({name, "_pkts_left"}, exp_pkt_q.size(), 0);
        check({name, "_raddr_left"}, exp_raddr_q.size(), 0);
    endtask

    logic [3:0] burst_raddr [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                    4'b0111, 4'b0101, 4'b0100, 4'b1100};

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        prev_raddr = 4'd0;

        // 1. Reset state
        do_reset();
        check("rst_raddr", fifo_raddr_o, 0);
        check("rst_packet", packet_o, 0);
        check("rst_valid", packet_valid_o, 0);
        check("rst_level", fill_level_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_err", err_o, 0);
        step(4);
        check("idle_valid", packet_valid_o, 0);
        check("idle_empty", empty_o, 1);
        check("idle_raddr", fifo_raddr_o, 0);

        // 2. Single packet, latency SYNC_STAGES+1
        load(8'hA5, 0, 1);
        exp_raddr_q.push_back(4'b0001);
        fifo_waddr_i = 4'b0001;
        step(2);
        check("single_valid_edge2", packet_valid_o, 0);
        step(1);
        check("single_valid_edge3", packet_valid_o, 1);
        check("single_packet", packet_o, 8'hA5);
        check("single_raddr", fifo_raddr_o, 4'b0001);
        packet_ready_i = 1'b1;
        step(1);
        check("single_valid_drop", packet_valid_o, 0);
        check("single_empty", empty_o, 1);
        packet_ready_i = 1'b0;
        drain("single", 5);

        // 3. Burst of eight at full rate
        do_reset();
        load(8'h10, 0, 8);
        for (int i = 0; i < 8; i++) exp_raddr_q.push_back(burst_raddr[i]);
        fifo_waddr_i   = 4'b1100;
        packet_ready_i = 1'b1;
        step(3);
        for (int i = 0; i < 8; i++) begin
            check("burst_valid_each_cycle", packet_valid_o, 1);
            step(1);
        end
        check("burst_valid_end", packet_valid_o, 0);
        drain("burst", 20);
        step(2);
        check("burst_level", fill_level_o, 0);
        check("burst_empty", empty_o, 1);

        // 4. Backpressure
        do_reset();
        load(8'h10, 0, 8);
        push_raddr(0, 8);
        fifo_waddr_i   = 4'b1100;
        packet_ready_i = 1'b0;
        step(10);
        check("bp_raddr", fifo_raddr_o, 4'b0011);
        check("bp_level", fill_level_o, 6);
        check("bp_valid", packet_valid_o, 1);
        check("bp_head", packet_o, 8'h10);
        check("bp_empty", empty_o, 0);
        packet_ready_i = 1'b1;
        drain("bp", 30);
        step(2);
        check("bp_level_end", fill_level_o, 0);

        // 5. Pointer wrap through 15 -> 0
        do_reset();
        load(8'h40, 0, 8);
        push_raddr(0, 8);
        fifo_waddr_i   = 4'b1100;
        packet_ready_i = 1'b1;
        drain("wrap_pre1", 30);
        load(8'h48, 0, 6);
        push_raddr(8, 6);
        fifo_waddr_i = 4'b1001;
        drain("wrap_pre2", 30);
        load(8'h50, 6, 4);
        exp_raddr_q.push_back(4'b1000);
        exp_raddr_q.push_back(4'b0000);
        exp_raddr_q.push_back(4'b0001);
        exp_raddr_q.push_back(4'b0011);
        fifo_waddr_i = 4'b0011;
        drain("wrap", 30);
        step(2);
        check("wrap_level", fill_level_o, 0);
        check("wrap_empty", empty_o, 1);

        // 6a. Overflowed write pointer with nothing read
        do_reset();
        fifo_waddr_i = 4'b1111;
        step(2);
        check("err_edge2", err_o, 0);
        step(1);
        check("err_edge3", err_o, 1);
        step(4);
        check("err_no_fetch_valid", packet_valid_o, 0);
        check("err_no_fetch_raddr", fifo_raddr_o, 0);
        fifo_waddr_i = 4'b0000;
        step(5);
        check("err_sticky", err_o, 1);
        do_reset();
        check("err_cleared", err_o, 0);

        // 6b. Buffered packets still drain after an error
        load(8'h30, 0, 2);
        push_raddr(0, 2);
        fifo_waddr_i   = 4'b0011;
        packet_ready_i = 1'b0;
        step(6);
        fifo_waddr_i = 4'b1010;
        step(5);
        check("err_drain_err", err_o, 1);
        check("err_drain_raddr", fifo_raddr_o, 4'b0011);
        check("err_drain_level", fill_level_o, 10);
        packet_ready_i = 1'b1;
        drain("err_drain", 10);
        step(3);
        check("err_drain_valid_end", packet_valid_o, 0);
        check("err_drain_raddr_end", fifo_raddr_o, 4'b0011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
